// File: rtl/alu_sequencer.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | alu_sequencer: fetch/decode/execute controller for the 8-bit accumulator  |
// | ALU. Optional single-step mode: define SEQ_SINGLE_STEP_EN. Rev 1.0        |
// +---------------------------------------------------------------------------+
module alu_sequencer #(
  parameter logic [3:0]  START_PC   = 4'd0,
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iSTART,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic       iSTEP,
`endif
  output logic [3:0] oMEM_ADDR,
  output logic       oMEM_RD,
  output logic       oMEM_WR,
  output logic [7:0] oMEM_WDATA,
  input  logic [7:0] iMEM_RDATA,
  input  logic       iMEM_READY,
  output logic [3:0] oALU_OP,
  output logic [7:0] oALU_IN1,
  output logic [7:0] oALU_IN2,
  input  logic [7:0] iALU_Z,
  output logic [7:0] oACC,
  output logic [3:0] oPC,
  output logic       oBUSY,
  output logic       oHALT,
  output logic       oERR
);

  localparam logic [3:0] OP_ADD    = 4'h4;
  localparam logic [3:0] OP_STA    = 4'h5;
  localparam logic [3:0] OP_LDA    = 4'h6;
  localparam logic [3:0] OP_JMP    = 4'h7;
  localparam logic [3:0] OP_HLT    = 4'hF;
  localparam logic [3:0] ALU_IDLE  = 4'hF;
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_DECODE   = 3'd2,
    S_OPRD     = 3'd3,
    S_EXEC     = 3'd4,
    S_STORE    = 3'd5,
    S_HALT     = 3'd6
`ifdef SEQ_SINGLE_STEP_EN
    ,S_STEPWAIT = 3'd7
`endif
  } state_t;

  // Every path that would enter FETCH goes through FETCH_ENTRY; in step mode
  // that is STEPWAIT, where no request is raised and BUSY stays low.
`ifdef SEQ_SINGLE_STEP_EN
  localparam state_t FETCH_ENTRY  = S_STEPWAIT;
  localparam logic   FETCH_DIRECT = 1'b0;
`else
  localparam state_t FETCH_ENTRY  = S_FETCH;
  localparam logic   FETCH_DIRECT = 1'b1;
`endif

  state_t     state_q;
  logic [3:0] pc_q;
  logic [7:0] ir_q;
  logic [7:0] acc_q;
  logic [7:0] opr_q;
  logic [7:0] wait_q;
  logic [3:0] addr_q;
  logic [7:0] wdata_q;
  logic [3:0] alu_op_q;
  logic       rd_q;
  logic       wr_q;
  logic       busy_q;
  logic       halt_q;
  logic       err_q;

  logic [3:0] opcode_d;
  logic [3:0] pc_inc_d;

  assign opcode_d = ir_q[7:4];
  assign pc_inc_d = pc_q + 4'd1;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q  <= S_IDLE;
      pc_q     <= START_PC;
      ir_q     <= 8'h00;
      acc_q    <= 8'h00;
      opr_q    <= 8'h00;
      wait_q   <= 8'h00;
      addr_q   <= 4'h0;
      wdata_q  <= 8'h00;
      alu_op_q <= ALU_IDLE;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      busy_q   <= 1'b0;
      halt_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_HALT: begin
          if (iSTART) begin
            pc_q    <= START_PC;
            err_q   <= 1'b0;
            halt_q  <= 1'b0;
            state_q <= FETCH_ENTRY;
            rd_q    <= FETCH_DIRECT;
            busy_q  <= FETCH_DIRECT;
            addr_q  <= START_PC;
            wait_q  <= 8'h00;
          end
        end

        // Shared handshake for instruction fetch, operand read and store.
        S_FETCH, S_OPRD, S_STORE: begin
          if (iMEM_READY) begin
            rd_q <= 1'b0;
            wr_q <= 1'b0;
            if (state_q == S_FETCH) begin
              ir_q    <= iMEM_RDATA;
              pc_q    <= pc_inc_d;
              state_q <= S_DECODE;
            end else if (state_q == S_OPRD) begin
              opr_q    <= iMEM_RDATA;
              alu_op_q <= opcode_d;
              state_q  <= S_EXEC;
            end else begin
              state_q <= FETCH_ENTRY;
              rd_q    <= FETCH_DIRECT;
              busy_q  <= FETCH_DIRECT;
              addr_q  <= pc_q;
              wait_q  <= 8'h00;
            end
          end else if (wait_q == WAIT_LAST) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b1;
            halt_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_HALT;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end

        S_DECODE: begin
          case (opcode_d)
            4'h0, 4'h1, 4'h2, 4'h3: begin
              alu_op_q <= opcode_d;
              state_q  <= S_EXEC;
            end
            OP_ADD, OP_LDA: begin
              rd_q    <= 1'b1;
              addr_q  <= ir_q[3:0];
              wait_q  <= 8'h00;
              state_q <= S_OPRD;
            end
            OP_STA: begin
              wr_q    <= 1'b1;
              addr_q  <= ir_q[3:0];
              wdata_q <= acc_q;
              wait_q  <= 8'h00;
              state_q <= S_STORE;
            end
            OP_JMP: begin
              pc_q    <= ir_q[3:0];
              state_q <= FETCH_ENTRY;
              rd_q    <= FETCH_DIRECT;
              busy_q  <= FETCH_DIRECT;
              addr_q  <= ir_q[3:0];
              wait_q  <= 8'h00;
            end
            OP_HLT: begin
              halt_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_HALT;
            end
            default: begin
              state_q <= FETCH_ENTRY;
              rd_q    <= FETCH_DIRECT;
              busy_q  <= FETCH_DIRECT;
              addr_q  <= pc_q;
              wait_q  <= 8'h00;
            end
          endcase
        end

        S_EXEC: begin
          acc_q    <= iALU_Z;
          alu_op_q <= ALU_IDLE;
          state_q  <= FETCH_ENTRY;
          rd_q     <= FETCH_DIRECT;
          busy_q   <= FETCH_DIRECT;
          addr_q   <= pc_q;
          wait_q   <= 8'h00;
        end

`ifdef SEQ_SINGLE_STEP_EN
        S_STEPWAIT: begin
          if (iSTEP) begin
            state_q <= S_FETCH;
            rd_q    <= 1'b1;
            busy_q  <= 1'b1;
            addr_q  <= pc_q;
            wait_q  <= 8'h00;
          end
        end
`endif

        default: begin
          state_q  <= S_IDLE;
          rd_q     <= 1'b0;
          wr_q     <= 1'b0;
          busy_q   <= 1'b0;
          halt_q   <= 1'b0;
          alu_op_q <= ALU_IDLE;
        end
      endcase
    end
  end

  assign oMEM_ADDR  = addr_q;
  assign oMEM_RD    = rd_q;
  assign oMEM_WR    = wr_q;
  assign oMEM_WDATA = wdata_q;
  assign oALU_OP    = alu_op_q;
  assign oALU_IN1   = acc_q;
  assign oALU_IN2   = opr_q;
  assign oACC       = acc_q;
  assign oPC        = pc_q;
  assign oBUSY      = busy_q;
  assign oHALT      = halt_q;
  assign oERR       = err_q;

endmodule
`default_nettype wire
